// File: rtl/pi_ctrl_seq.sv
// PI motor-control sequencer: steps the shared combinational ALU through the
// integral / proportional / output micro-program and holds the operand registers.
module pi_ctrl_seq #(
    parameter logic [13:0] PTERM = 14'h3680,
    parameter logic [11:0] ITERM = 12'h500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [11:0] err_in,
    input  logic [11:0] fwd_in,
    input  logic [15:0] alu_dst,
    output logic [15:0] Accum,
    output logic [15:0] Pcomp,
    output logic [13:0] Pterm,
    output logic [11:0] Iterm,
    output logic [11:0] Error,
    output logic [11:0] Intgrl,
    output logic [11:0] Icomp,
    output logic [11:0] Fwd,
    output logic [2:0]  src1sel,
    output logic [2:0]  src0sel,
    output logic        multiply,
    output logic        sub,
    output logic        mult2,
    output logic        mult4,
    output logic        saturate,
    output logic [11:0] lft,
    output logic [11:0] rht,
    output logic        busy,
    output logic        done
);

    // state  | meaning
    // IDLE   | waiting for go; operands captured on accept
    // INTG   | Intgrl += Error>>4, saturated
    // ICOMP  | Icomp = Iterm * Intgrl
    // PCOMP  | Pcomp = Error * Pterm
    // RHT1   | Accum = Fwd - Pcomp
    // RHT2   | rht = sat(Accum - Icomp)
    // LFT1   | Accum = Fwd + Pcomp
    // LFT2   | lft = sat(Accum + Icomp)
    // DONE   | commands valid, done pulse
    typedef enum logic [3:0] {
        S_IDLE, S_INTG, S_ICOMP, S_PCOMP, S_RHT1, S_RHT2, S_LFT1, S_LFT2, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] error_q, error_d;
    logic [11:0] fwd_q, fwd_d;
    logic [11:0] intgrl_q, intgrl_d;
    logic [11:0] icomp_q, icomp_d;
    logic [15:0] pcomp_q, pcomp_d;
    logic [15:0] accum_q, accum_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rht_q, rht_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            error_q  <= '0;
            fwd_q    <= '0;
            intgrl_q <= '0;
            icomp_q  <= '0;
            pcomp_q  <= '0;
            accum_q  <= '0;
            lft_q    <= '0;
            rht_q    <= '0;
        end else begin
            state_q  <= state_d;
            error_q  <= error_d;
            fwd_q    <= fwd_d;
            intgrl_q <= intgrl_d;
            icomp_q  <= icomp_d;
            pcomp_q  <= pcomp_d;
            accum_q  <= accum_d;
            lft_q    <= lft_d;
            rht_q    <= rht_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_INTG;
            S_INTG:  state_d = S_ICOMP;
            S_ICOMP: state_d = S_PCOMP;
            S_PCOMP: state_d = S_RHT1;
            S_RHT1:  state_d = S_RHT2;
            S_RHT2:  state_d = S_LFT1;
            S_LFT1:  state_d = S_LFT2;
            S_LFT2:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Each step captures the ALU result at the end of the step that produced it.
    always_comb begin
        error_d  = error_q;
        fwd_d    = fwd_q;
        intgrl_d = intgrl_q;
        icomp_d  = icomp_q;
        pcomp_d  = pcomp_q;
        accum_d  = accum_q;
        lft_d    = lft_q;
        rht_d    = rht_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    error_d = err_in;
                    fwd_d   = fwd_in;
                end
            end
            S_INTG:  intgrl_d = alu_dst[11:0];
            S_ICOMP: icomp_d  = alu_dst[11:0];
            S_PCOMP: pcomp_d  = alu_dst;
            S_RHT1:  accum_d  = alu_dst;
            S_RHT2:  rht_d    = alu_dst[11:0];
            S_LFT1:  accum_d  = alu_dst;
            S_LFT2:  lft_d    = alu_dst[11:0];
            default: ;
        endcase
    end

    always_comb begin
        src1sel  = 3'd0;
        src0sel  = 3'd0;
        multiply = 1'b0;
        sub      = 1'b0;
        mult2    = 1'b0;
        mult4    = 1'b0;
        saturate = 1'b0;
        case (state_q)
            S_INTG:  begin src1sel = 3'd3; src0sel = 3'd1; saturate = 1'b1; end
            S_ICOMP: begin src1sel = 3'd1; src0sel = 3'd1; multiply = 1'b1; end
            S_PCOMP: begin src1sel = 3'd2; src0sel = 3'd4; multiply = 1'b1; end
            S_RHT1:  begin src1sel = 3'd4; src0sel = 3'd3; sub = 1'b1; end
            S_RHT2:  begin src1sel = 3'd0; src0sel = 3'd2; sub = 1'b1; saturate = 1'b1; end
            S_LFT1:  begin src1sel = 3'd4; src0sel = 3'd3; end
            S_LFT2:  begin src1sel = 3'd0; src0sel = 3'd2; saturate = 1'b1; end
            default: ;
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign Accum  = accum_q;
    assign Pcomp  = pcomp_q;
    assign Pterm  = PTERM;
    assign Iterm  = ITERM;
    assign Error  = error_q;
    assign Intgrl = intgrl_q;
    assign Icomp  = icomp_q;
    assign Fwd    = fwd_q;
    assign lft    = lft_q;
    assign rht    = rht_q;

endmodule

// File: tb/tb_pi_ctrl_seq.sv
// Bench for pi_ctrl_seq: models the external ALU, queues hand-computed results per
// request and checks them in a done-triggered monitor.
module tb_pi_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst, go;
    logic [11:0] err_in, fwd_in;
    logic [15:0] alu_dst;
    logic [15:0] Accum, Pcomp;
    logic [13:0] Pterm;
    logic [11:0] Iterm, Error, Intgrl, Icomp, Fwd, lft, rht;
    logic [2:0]  src1sel, src0sel;
    logic        multiply, sub, mult2, mult4, saturate, busy, done;

    pi_ctrl_seq dut (
        .clk(clk), .rst(rst), .go(go), .err_in(err_in), .fwd_in(fwd_in),
        .alu_dst(alu_dst), .Accum(Accum), .Pcomp(Pcomp), .Pterm(Pterm),
        .Iterm(Iterm), .Error(Error), .Intgrl(Intgrl), .Icomp(Icomp), .Fwd(Fwd),
        .src1sel(src1sel), .src0sel(src0sel), .multiply(multiply), .sub(sub),
        .mult2(mult2), .mult4(mult4), .saturate(saturate), .lft(lft), .rht(rht),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line-follower ALU (A2D_res tied to 0)
    function automatic logic [15:0] alu_model(
        input logic [2:0] s1, input logic [2:0] s0, input logic mul, input logic sb,
        input logic m2, input logic m4, input logic sat,
        input logic [15:0] acc, input logic [15:0] pc, input logic [13:0] pt,
        input logic [11:0] it, input logic [11:0] er, input logic [11:0] ig,
        input logic [11:0] ic, input logic [11:0] fw);
        logic [15:0] a, b, bs, sum, sum_sat, mul_sat;
        logic signed [29:0] prod;
        case (s1)
            3'd0: a = acc;
            3'd1: a = {4'b0, it};
            3'd2: a = {{4{er[11]}}, er};
            3'd3: a = {{8{er[11]}}, er[11:4]};
            3'd4: a = {4'b0, fw};
            default: a = 16'h0;
        endcase
        case (s0)
            3'd1: b = {{4{ig[11]}}, ig};
            3'd2: b = {{4{ic[11]}}, ic};
            3'd3: b = pc;
            3'd4: b = {2'b0, pt};
            default: b = 16'h0;
        endcase
        bs  = m4 ? (b << 2) : (m2 ? (b << 1) : b);
        sum = a + (sb ? ~bs : bs) + {15'b0, sb};
        if (sum[15] && !(&sum[14:11]))      sum_sat = 16'hF800;
        else if (!sum[15] && (|sum[14:11])) sum_sat = 16'h07FF;
        else                                sum_sat = sum;
        prod = $signed(a[14:0]) * $signed(b[14:0]);
        if (prod[29] && !(&prod[28:26]))      mul_sat = 16'hC000;
        else if (!prod[29] && (|prod[28:26])) mul_sat = 16'h3FFF;
        else                                  mul_sat = prod[27:12];
        return mul ? mul_sat : (sat ? sum_sat : sum);
    endfunction

    always_comb alu_dst = alu_model(src1sel, src0sel, multiply, sub, mult2, mult4, saturate,
                                    Accum, Pcomp, Pterm, Iterm, Error, Intgrl, Icomp, Fwd);

    localparam logic [4:0] M_LFT = 5'd1, M_RHT = 5'd2, M_INT = 5'd4, M_ICMP = 5'd8, M_PCMP = 5'd16;

    typedef struct {
        int          cyc;
        logic [11:0] lft, rht, intgrl, icomp;
        logic [15:0] pcomp;
        logic [4:0]  mask;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_pass = 0, n_total = 0, done_cnt = 0;

    localparam logic [10:0] CTL_TAB [8] = '{
        11'b011_001_00001, 11'b001_001_10000, 11'b010_100_10000, 11'b100_011_01000,
        11'b000_010_01001, 11'b100_011_00000, 11'b000_010_00001, 11'b000_000_00000
    };
    logic [10:0] ctl;
    assign ctl = {src1sel, src0sel, multiply, sub, mult2, mult4, saturate};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t mk(input logic [11:0] l, input logic [11:0] r, input logic [11:0] ig,
                                input logic [11:0] ic, input logic [15:0] pc, input logic [4:0] m);
        exp_t e;
        e.cyc = 0; e.lft = l; e.rht = r; e.intgrl = ig; e.icomp = ic; e.pcomp = pc; e.mask = m;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: done=1 at cycle %0d expected no done", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                if (mon_e.mask & M_LFT)  check("lft", 32'(lft), 32'(mon_e.lft));
                if (mon_e.mask & M_RHT)  check("rht", 32'(rht), 32'(mon_e.rht));
                if (mon_e.mask & M_INT)  check("Intgrl", 32'(Intgrl), 32'(mon_e.intgrl));
                if (mon_e.mask & M_ICMP) check("Icomp", 32'(Icomp), 32'(mon_e.icomp));
                if (mon_e.mask & M_PCMP) check("Pcomp", 32'(Pcomp), 32'(mon_e.pcomp));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; go = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // go is sampled at the next edge; done is expected 7 edges after that.
    task automatic issue(input logic [11:0] err, input logic [11:0] fwd, input bit push, input exp_t e);
        exp_t ee;
        @(negedge clk);
        go = 1'b1; err_in = err; fwd_in = fwd;
        if (push) begin
            ee = e;
            ee.cyc = cyc + 8;
            exp_q.push_back(ee);
        end
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 32'(k < 60), 32'd1);
    endtask

    localparam logic [4:0] M_ALL = M_LFT | M_RHT | M_INT | M_ICMP | M_PCMP;

    initial begin
        int d0, ei;
        rst = 1'b1; go = 1'b0; err_in = '0; fwd_in = '0;

        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ctl", 32'(ctl), 0);
        check("rst_lft", 32'(lft), 0);
        check("rst_rht", 32'(rht), 0);
        check("rst_Intgrl", 32'(Intgrl), 0);
        check("rst_Icomp", 32'(Icomp), 0);
        check("rst_Pcomp", 32'(Pcomp), 0);
        check("rst_Accum", 32'(Accum), 0);
        check("rst_Error", 32'(Error), 0);
        check("rst_Fwd", 32'(Fwd), 0);
        check("Pterm", 32'(Pterm), 32'h3680);
        check("Iterm", 32'(Iterm), 32'h500);

        // zero error: commands equal forward speed
        issue(12'h000, 12'h300, 1, mk(12'h300, 12'h300, 12'h000, 12'h000, 16'h0000, M_ALL));
        wait_idle();

        // proportional path, with per-step control decode
        do_reset();
        issue(12'h010, 12'h300, 1, mk(12'h336, 12'h2CA, 12'h001, 12'h000, 16'h0036, M_ALL));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ctl_step%0d", i), 32'(ctl), 32'(CTL_TAB[i]));
            check($sformatf("busy_step%0d", i), 32'(busy), 1);
            @(negedge clk);
        end
        check("busy_after_done", 32'(busy), 0);
        wait_idle();

        // output saturation
        do_reset();
        issue(12'h100, 12'h7F0, 1, mk(12'h7FF, 12'h000, 12'h010, 12'h000, 16'h0368, M_LFT | M_INT | M_PCMP));
        wait_idle();

        // integrator saturation: +0x7F per request, clamps at 0x7FF
        do_reset();
        for (int n = 1; n <= 18; n++) begin
            ei = n * 127;
            if (ei > 2047) ei = 2047;
            issue(12'h7FF, 12'h000, 1,
                  mk(12'h0, 12'h0, 12'(ei), (n >= 17) ? 12'h27F : 12'h0, 16'h0,
                     (n >= 17) ? (M_INT | M_ICMP) : M_INT));
            wait_idle();
        end

        // go while busy ignored; go in first idle cycle after DONE accepted
        do_reset();
        d0 = done_cnt;
        err_in = 12'h010; fwd_in = 12'h300;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            go = (i == 0 || i == 3 || i == 7 || i == 8 || i == 9);
            if (i == 0) begin
                mon_e = mk(12'h336, 12'h2CA, 12'h001, 12'h000, 16'h0036, M_ALL);
                mon_e.cyc = cyc + 8;
                exp_q.push_back(mon_e);
            end
            if (i == 9) begin
                mon_e = mk(12'h336, 12'h2CA, 12'h002, 12'h000, 16'h0036, M_ALL);
                mon_e.cyc = cyc + 8;
                exp_q.push_back(mon_e);
            end
        end
        @(negedge clk);
        go = 1'b0;
        wait_idle();
        check("busy_done_count", 32'(done_cnt - d0), 2);

        // reset abort in PCOMP
        issue(12'h100, 12'h7F0, 0, mk(12'h0, 12'h0, 12'h0, 12'h0, 16'h0, 5'd0));
        @(negedge clk);
        @(negedge clk);
        check("abort_in_pcomp", 32'(ctl), 32'(CTL_TAB[2]));
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_Intgrl", 32'(Intgrl), 0);
        check("abort_lft", 32'(lft), 0);
        check("abort_rht", 32'(rht), 0);
        check("abort_Error", 32'(Error), 0);
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 0);
        check("abort_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
